// File: rtl/sys_defs.sv
// Shared types for the PE array and its partial-sum buffer: psum packet,
// array operating mode and the default per-column buffer depth.
package sys_defs;

    localparam int PSUM_W         = 32;
    localparam int PSUM_BUF_DEPTH = 16;
    localparam int PE_COLS        = 7;

    typedef enum logic [1:0] {
        MODE1 = 2'd0,
        MODE2 = 2'd1,
        MODE3 = 2'd2,
        MODE4 = 2'd3
    } OP_MODE;

    typedef struct packed {
        logic              valid;
        logic [PSUM_W-1:0] data;
    } PSUM_PACKET;

endpackage

// File: rtl/psum_buffer_col_fifo.sv
// One column of the psum buffer: circular storage with wrapping pointers and an
// occupancy count. The count port exists only when PSUM_BUF_STATS_EN is defined.
module psum_col_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = PSUM_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [PSUM_W-1:0]          wdata,
    output logic [PSUM_W-1:0]          rdata,
    output logic                       empty,
`ifdef PSUM_BUF_STATS_EN
    output logic [$clog2(DEPTH):0]     count,
`endif
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);

    logic [PSUM_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && !clear && push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
`ifdef PSUM_BUF_STATS_EN
    assign count = count_q;
`endif

endmodule

// File: rtl/psum_buffer.sv
// Per-column psum store between PE row 5 (drain in MODE1) and row 0 (replay in MODE2).
// Optional PSUM_BUF_STATS_EN adds high_water and dropped_cnt outputs.
module psum_buffer
    import sys_defs::*;
#(
    parameter int DEPTH = PSUM_BUF_DEPTH,
    parameter int COLS  = PE_COLS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  OP_MODE                        mode_in,
    input  logic                          change_mode,
    input  logic                          clear,
    input  PSUM_PACKET [COLS-1:0]         psum_in,
    output logic       [COLS-1:0]         psum_in_ack,
    output PSUM_PACKET [COLS-1:0]         psum_out,
    input  logic       [COLS-1:0]         psum_out_ack,
    output logic       [COLS-1:0]         col_empty,
    output logic       [COLS-1:0]         col_full,
`ifdef PSUM_BUF_STATS_EN
    output logic [COLS-1:0][$clog2(DEPTH):0] high_water,
    output logic [15:0]                   dropped_cnt,
`endif
    output logic                          overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    OP_MODE            cur_mode_q;
    logic              overflow_q;
    logic [COLS-1:0]   push;
    logic [COLS-1:0]   pop;
    logic [COLS-1:0]   ovf_col;
    logic              mode_is1;
    logic              mode_is2;

    assign mode_is1 = (cur_mode_q == MODE1);
    assign mode_is2 = (cur_mode_q == MODE2);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_mode_q <= MODE1;
        end else if (change_mode) begin
            cur_mode_q <= mode_in;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            logic [PSUM_W-1:0] head_data;
`ifdef PSUM_BUF_STATS_EN
            logic [CW-1:0]     col_count;
            logic [CW-1:0]     hw_q;
`endif

            assign psum_in_ack[gi] = mode_is1 & psum_in[gi].valid & ~col_full[gi];
            assign ovf_col[gi]     = mode_is1 & psum_in[gi].valid &  col_full[gi];
            // clear still shows the combinational ack but must not store the datum.
            assign push[gi]        = psum_in_ack[gi] & ~clear;
            assign pop[gi]         = mode_is2 & psum_out_ack[gi] & ~col_empty[gi] & ~clear;

            assign psum_out[gi].valid = mode_is2 & ~col_empty[gi];
            assign psum_out[gi].data  = psum_out[gi].valid ? head_data : '0;

            psum_col_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .clear (clear),
                .push  (push[gi]),
                .pop   (pop[gi]),
                .wdata (psum_in[gi].data),
                .rdata (head_data),
                .empty (col_empty[gi]),
`ifdef PSUM_BUF_STATS_EN
                .count (col_count),
`endif
                .full  (col_full[gi])
            );

`ifdef PSUM_BUF_STATS_EN
            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    hw_q <= '0;
                end else if (col_count > hw_q) begin
                    hw_q <= col_count;
                end
            end
            assign high_water[gi] = hw_q;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            overflow_q <= 1'b0;
        end else if (|ovf_col) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;

`ifdef PSUM_BUF_STATS_EN
    logic [15:0] dropped_cnt_q;

    // Counts cycles carrying an overflow event; saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped_cnt_q <= '0;
        end else if (!clear && (|ovf_col) && (dropped_cnt_q != 16'hFFFF)) begin
            dropped_cnt_q <= dropped_cnt_q + 16'd1;
        end
    end

    assign dropped_cnt = dropped_cnt_q;
`endif

endmodule
